// File: rtl/ucsbece154b_store_buffer_pkg.sv
// Shared definitions for the store buffer: default sizes and occupancy
// classification derived from the registered entry count.
package ucsbece154b_store_buffer_pkg;

  localparam int unsigned SB_DEPTH  = 4;
  localparam int unsigned SB_DATA_W = 32;
  localparam int unsigned SB_ADDR_W = 32;

  // Occupancy states; these are a view of count, not a separate register.
  localparam logic [1:0] OCC_EMPTY  = 2'd0;
  localparam logic [1:0] OCC_ACTIVE = 2'd1;
  localparam logic [1:0] OCC_FULL   = 2'd2;

  // Classify a count value against the buffer depth.
  function automatic logic [1:0] sb_occ(input int unsigned cnt, input int unsigned depth);
    if (cnt == 0) begin
      return OCC_EMPTY;
    end else if (cnt >= depth) begin
      return OCC_FULL;
    end
    return OCC_ACTIVE;
  endfunction

endpackage

// File: rtl/ucsbece154b_store_buffer_if.sv
// Core / DMEM side bundle of the store buffer.
//   st_*   : store request from the core, st_ready_o back-pressure
//   ld_*   : load lookup (forwarding) from the core
//   mem_*  : write request towards DMEM
//   empty_o: drain status for fence / halt
// slave  = the store buffer, master = core + DMEM environment.
interface ucsbece154b_store_buffer_if
  import ucsbece154b_store_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SB_DATA_W,
  parameter int unsigned ADDR_WIDTH = SB_ADDR_W
);

  logic                  st_valid_i;
  logic [ADDR_WIDTH-1:0] st_addr_i;
  logic [DATA_WIDTH-1:0] st_data_i;
  logic                  st_ready_o;

  logic                  ld_valid_i;
  logic [ADDR_WIDTH-1:0] ld_addr_i;
  logic                  ld_hit_o;
  logic [DATA_WIDTH-1:0] ld_data_o;

  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_ready_i;

  logic                  empty_o;

  modport slave (
    input  st_valid_i, st_addr_i, st_data_i,
    output st_ready_o,
    input  ld_valid_i, ld_addr_i,
    output ld_hit_o, ld_data_o,
    output mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ready_i,
    output empty_o
  );

  modport master (
    output st_valid_i, st_addr_i, st_data_i,
    input  st_ready_o,
    output ld_valid_i, ld_addr_i,
    input  ld_hit_o, ld_data_o,
    input  mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ready_i,
    input  empty_o
  );

endinterface

// File: rtl/ucsbece154b_sb_fwd.sv
// Store-to-load forwarding: DEPTH-way word-address compare with a
// youngest-first select relative to the tail pointer.
//   entry_waddr_i : word addresses (addr[31:2]) of all slots
//   entry_data_i  : data of all slots
//   valid_i       : slot valid mask
//   tail_i        : next write slot (oldest-possible position)
//   ld_waddr_i    : load word address
//   ld_hit_o      : some valid slot matches
//   ld_data_o     : data of the youngest match, 0 when no hit
module ucsbece154b_sb_fwd #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WADDR_WIDTH = 30
) (
  input  logic [DEPTH-1:0][WADDR_WIDTH-1:0] entry_waddr_i,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0]  entry_data_i,
  input  logic [DEPTH-1:0]                  valid_i,
  input  logic [$clog2(DEPTH)-1:0]          tail_i,
  input  logic [WADDR_WIDTH-1:0]            ld_waddr_i,
  output logic                              ld_hit_o,
  output logic [DATA_WIDTH-1:0]             ld_data_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx_c;

  // Walk slots from tail upward (oldest to youngest); later matches override,
  // so the youngest matching store wins. Invalid slots sit before head in
  // this order and are skipped by the valid mask.
  always_comb begin
    ld_hit_o  = 1'b0;
    ld_data_o = '0;
    idx_c     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx_c = tail_i + PTR_W'(i);
      if (valid_i[idx_c] && (entry_waddr_i[idx_c] == ld_waddr_i)) begin
        ld_hit_o  = 1'b1;
        ld_data_o = entry_data_i[idx_c];
      end
    end
  end

endmodule

// File: rtl/ucsbece154b_store_buffer.sv
// Write buffer between the memory stage and DMEM. Retired stores queue in a
// FIFO and drain to DMEM whenever no load owns the port; loads forward from
// the youngest pending store to the same word.
//   clk, reset_n : clock, async active-low reset
//   sb (slave)   : store, load-lookup, DMEM write and empty signals
module ucsbece154b_store_buffer
  import ucsbece154b_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = SB_DEPTH,
  parameter int unsigned DATA_WIDTH = SB_DATA_W,
  parameter int unsigned ADDR_WIDTH = SB_ADDR_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  ucsbece154b_store_buffer_if.slave  sb
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WA_W  = ADDR_WIDTH - 2;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  logic [DEPTH-1:0][WA_W-1:0]       waddr_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;

  logic [1:0]            occ_c;
  logic                  enq_c;
  logic                  deq_c;
  logic                  mem_we_c;
  logic                  ld_hit_c;
  logic [DATA_WIDTH-1:0] ld_data_c;
  logic                  unused_c;

  // Byte-offset bits play no part in word matching or DMEM addressing.
  assign unused_c = ^{sb.st_addr_i[1:0], sb.ld_addr_i[1:0]};

  // Occupancy comes from the registered count only, so st_ready_o has no
  // path from mem_ready_i; a full buffer refuses stores even on a dequeue cycle.
  assign occ_c    = sb_occ(32'(count_q), DEPTH);
  assign mem_we_c = (occ_c != OCC_EMPTY) && !sb.ld_valid_i;
  assign enq_c    = sb.st_valid_i && (occ_c != OCC_FULL);
  assign deq_c    = mem_we_c && sb.mem_ready_i;

  assign sb.st_ready_o  = (occ_c != OCC_FULL);
  assign sb.empty_o     = (occ_c == OCC_EMPTY);
  assign sb.mem_we_o    = mem_we_c;
  // Head entry stays put until accepted, keeping the request stable.
  assign sb.mem_addr_o  = {waddr_q[head_q], 2'b00};
  assign sb.mem_wdata_o = data_q[head_q];
  assign sb.ld_hit_o    = ld_hit_c;
  assign sb.ld_data_o   = ld_data_c;

  // Pointer / count / valid next state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (enq_c) begin
      tail_d         = tail_q + PTR_W'(1);
      valid_d[tail_q] = 1'b1;
    end
    if (deq_c) begin
      head_d         = head_q + PTR_W'(1);
      valid_d[head_q] = 1'b0;
    end
    case ({enq_c, deq_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards every pending store.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry payload; qualified by valid_q, so no reset needed.
  always_ff @(posedge clk) begin
    if (enq_c) begin
      waddr_q[tail_q] <= sb.st_addr_i[ADDR_WIDTH-1:2];
      data_q[tail_q]  <= sb.st_data_i;
    end
  end

  ucsbece154b_sb_fwd #(
    .DEPTH       (DEPTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .WADDR_WIDTH (WA_W)
  ) u_fwd (
    .entry_waddr_i (waddr_q),
    .entry_data_i  (data_q),
    .valid_i       (valid_q),
    .tail_i        (tail_q),
    .ld_waddr_i    (sb.ld_addr_i[ADDR_WIDTH-1:2]),
    .ld_hit_o      (ld_hit_c),
    .ld_data_o     (ld_data_c)
  );

endmodule

// File: tb/tb_ucsbece154b_store_buffer.sv
module tb_ucsbece154b_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ucsbece154b_store_buffer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) sb();

  ucsbece154b_store_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sb      (sb)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;

  st_t  model_q[$];   // pending stores, program order
  st_t  exp_q[$];     // scoreboard: expected DMEM writes
  int   total = 0;
  int   bad = 0;
  logic last_acc = 1'b0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a program-order queue of pending stores.
  always @(negedge clk) begin : model
    int          n;
    logic        fhit;
    logic [31:0] fdata;
    logic        exp_we;
    logic        enq;
    logic        deq;
    if (!reset_n) begin
      model_q.delete();
      exp_q.delete();
      last_acc = 1'b0;
      chk1("rst_st_ready", sb.st_ready_o, 1'b1);
      chk1("rst_empty", sb.empty_o, 1'b1);
      chk1("rst_mem_we", sb.mem_we_o, 1'b0);
      chk1("rst_ld_hit", sb.ld_hit_o, 1'b0);
      chk32("rst_ld_data", sb.ld_data_o, 32'h0);
    end else begin
      n = model_q.size();
      exp_we = (n > 0) && !sb.ld_valid_i;
      chk1("st_ready", sb.st_ready_o, n < DEPTH);
      chk1("empty", sb.empty_o, n == 0);
      chk1("mem_we", sb.mem_we_o, exp_we);
      if (n > 0) begin
        chk32("mem_addr_head", sb.mem_addr_o, {model_q[0].addr[31:2], 2'b00});
        chk32("mem_wdata_head", sb.mem_wdata_o, model_q[0].data);
      end
      fhit = 1'b0;
      fdata = 32'h0;
      foreach (model_q[i]) begin
        if (model_q[i].addr[31:2] == sb.ld_addr_i[31:2]) begin
          fhit = 1'b1;
          fdata = model_q[i].data;
        end
      end
      chk1("ld_hit", sb.ld_hit_o, fhit);
      chk32("ld_data", sb.ld_data_o, fdata);
      deq = exp_we && sb.mem_ready_i;
      enq = sb.st_valid_i && (n < DEPTH);
      if (deq) void'(model_q.pop_front());
      if (enq) begin
        model_q.push_back({sb.st_addr_i, sb.st_data_i});
        exp_q.push_back({sb.st_addr_i, sb.st_data_i});
      end
      last_acc = enq;
    end
  end

  // Monitor: every accepted DMEM write must be the next expected store.
  always @(negedge clk) begin : monitor
    st_t e;
    if (reset_n && sb.mem_we_o && sb.mem_ready_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dmem_write unexpected addr=%h data=%h t=%0t", sb.mem_addr_o, sb.mem_wdata_o, $time);
      end else begin
        e = exp_q.pop_front();
        chk32("dmem_addr_order", sb.mem_addr_o, {e.addr[31:2], 2'b00});
        chk32("dmem_data_order", sb.mem_wdata_o, e.data);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a store and hold it until the buffer takes it.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    int guard;
    sb.st_valid_i = 1'b1;
    sb.st_addr_i  = a;
    sb.st_data_i  = d;
    guard = 0;
    do begin
      step();
      guard++;
    end while (!last_acc && guard < 200);
    chk1("store_accepted", last_acc, 1'b1);
    sb.st_valid_i = 1'b0;
  endtask

  task automatic drain();
    int guard;
    sb.ld_valid_i  = 1'b0;
    sb.mem_ready_i = 1'b1;
    guard = 0;
    while (!sb.empty_o && guard < 50) begin
      step();
      guard++;
    end
    chk1("drain_empty", sb.empty_o, 1'b1);
  endtask

  task automatic pulse_reset();
    sb.st_valid_i = 1'b0;
    reset_n = 1'b0;
    #1;
    chk1("t1_empty", sb.empty_o, 1'b1);
    chk1("t1_mem_we", sb.mem_we_o, 1'b0);
    chk1("t1_st_ready", sb.st_ready_o, 1'b1);
    chk1("t1_ld_hit", sb.ld_hit_o, 1'b0);
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin : driver
    sb.st_valid_i  = 1'b0;
    sb.st_addr_i   = 32'h0;
    sb.st_data_i   = 32'h0;
    sb.ld_valid_i  = 1'b0;
    sb.ld_addr_i   = 32'h0;
    sb.mem_ready_i = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single store drains the following cycle.
    sb.mem_ready_i = 1'b1;
    store(32'h1000_0060, 32'd7);
    chk1("t2_mem_we", sb.mem_we_o, 1'b1);
    chk32("t2_mem_addr", sb.mem_addr_o, 32'h1000_0060);
    chk32("t2_mem_wdata", sb.mem_wdata_o, 32'd7);
    step();
    chk1("t2_empty", sb.empty_o, 1'b1);

    // Fill to full with DMEM stalled; the fifth store is held.
    sb.mem_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) store(32'h1000_0000 + 32'(4 * i), 32'h100 + 32'(i));
    fork
      store(32'h1000_0010, 32'h104);
      begin
        chk1("t3_full", sb.st_ready_o, 1'b0);
        repeat (3) step();
        chk1("t3_held", sb.st_ready_o, 1'b0);
        chk32("t3_head", sb.mem_addr_o, 32'h1000_0000);
        sb.mem_ready_i = 1'b1;
      end
    join
    drain();

    // Forwarding from the youngest duplicate, then load priority on DMEM.
    sb.mem_ready_i = 1'b0;
    store(32'h1000_006C, 32'h11);
    store(32'h1000_006C, 32'h19);
    sb.ld_valid_i = 1'b1;
    sb.ld_addr_i  = 32'h1000_006E;
    #1;
    chk1("t4_hit", sb.ld_hit_o, 1'b1);
    chk32("t4_data", sb.ld_data_o, 32'h19);
    sb.ld_addr_i = 32'h1000_0070;
    #1;
    chk1("t4_miss", sb.ld_hit_o, 1'b0);
    chk32("t4_miss_data", sb.ld_data_o, 32'h0);
    sb.mem_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("t5_we_blocked", sb.mem_we_o, 1'b0);
      chk32("t5_head_addr", sb.mem_addr_o, 32'h1000_006C);
      chk32("t5_head_data", sb.mem_wdata_o, 32'h11);
    end
    drain();

    // Steady enqueue + dequeue across pointer wrap.
    sb.mem_ready_i = 1'b0;
    store(32'h2000_0000, 32'hA0);
    store(32'h2000_0004, 32'hA1);
    sb.mem_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sb.ld_addr_i = 32'h1000_0100 + 32'(4 * ((i + 2) % 3));
      store(32'h1000_0100 + 32'(4 * (i % 3)), 32'hB00 + 32'(i));
      chk1("t6_not_empty", sb.empty_o, 1'b0);
      chk1("t6_ready", sb.st_ready_o, 1'b1);
    end
    drain();

    // Randomized traffic with a reset pulse while stores are pending.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) pulse_reset();
      if (!(sb.st_valid_i && !last_acc)) begin
        sb.st_valid_i = ($urandom % 100) < 50;
        sb.st_addr_i  = 32'h1000_0000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
        sb.st_data_i  = $urandom;
      end
      sb.ld_valid_i  = ($urandom % 100) < 25;
      sb.ld_addr_i   = 32'h1000_0000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
      sb.mem_ready_i = (c >= 185 && c < 200) ? 1'b0 : (($urandom % 100) < 60);
      step();
    end
    sb.st_valid_i = 1'b0;
    drain();
    step();
    chk32("final_scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
